// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and load/store.
// Latches the winner's request, runs a req/ack backend handshake and returns ready pulses and stalls.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_ren,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_ready,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_ready,
  output logic              port_req,
  output logic              port_we,
  output logic [ADDR_W-1:0] port_addr,
  output logic [DATA_W-1:0] port_wdata,
  input  logic              port_ack,
  input  logic [DATA_W-1:0] port_rdata,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INST = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              last_data;
  logic              dropped;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] inst_hold;
  logic [DATA_W-1:0] mem_hold;

  logic              pend_inst;
  logic              pend_data;
  logic              busy;
  logic              to_fire;
  logic              served;
  logic              finish;
  logic              cur_pend;
  logic              withdrawn;
  logic [DATA_W-1:0] rd_val;
  logic              grant;
  logic              grant_data;

  // Handshakes: requesters hold *_ren/*_wen as levels until their ready pulse; the backend sees
  // port_req held with stable addr/we/wdata until the cycle port_ack=1, which completes the access.
  assign pend_inst = inst_ren;
  assign pend_data = mem_ren | mem_wen;
  assign busy      = (state != S_IDLE);
  assign to_fire   = (TIMEOUT != 0) && busy && (cnt == CNT_W'(TIMEOUT));
  assign served    = busy && port_ack && !to_fire;
  assign finish    = served || to_fire;
  assign cur_pend  = (state == S_INST) ? pend_inst : pend_data;
  assign withdrawn = dropped || !cur_pend;
  assign rd_val    = served ? port_rdata : '0;

  assign inst_ready = finish && (state == S_INST) && !withdrawn;
  assign mem_ready  = finish && (state == S_DATA) && !withdrawn;
  assign inst_data  = inst_ready ? rd_val : inst_hold;
  assign mem_din    = (mem_ready && !we_q) ? rd_val : mem_hold;
  assign if_stall   = pend_inst && !inst_ready;
  assign mem_stall  = pend_data && !mem_ready;

  // The watchdog cycle already drops the request so the backend sees it abandoned.
  assign port_req   = busy && !to_fire;
  assign port_we    = (state == S_DATA) && we_q;
  assign port_addr  = addr_q;
  assign port_wdata = wdata_q;
  assign dbg_state  = state;

  always_comb begin
    grant      = 1'b0;
    grant_data = 1'b0;
    if (!busy) begin
      if (pend_data && pend_inst) begin
        grant      = 1'b1;
        grant_data = !last_data;
      end else if (pend_data || pend_inst) begin
        grant      = 1'b1;
        grant_data = pend_data;
      end
    end else if (finish) begin
      // Back-to-back grant only goes to the side that was not just served.
      if (state == S_INST && pend_data) begin
        grant      = 1'b1;
        grant_data = 1'b1;
      end else if (state == S_DATA && pend_inst) begin
        grant      = 1'b1;
        grant_data = 1'b0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (grant) state_nx = grant_data ? S_DATA : S_INST;
    else if (finish) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last_data <= 1'b0;
      dropped   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      inst_hold <= '0;
      mem_hold  <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        addr_q    <= grant_data ? mem_addr : inst_addr;
        wdata_q   <= grant_data ? mem_dout : '0;
        we_q      <= grant_data && mem_wen;
        last_data <= grant_data;
        cnt       <= '0;
        dropped   <= 1'b0;
      end else if (busy) begin
        cnt <= cnt + CNT_W'(1);
        if (!cur_pend) dropped <= 1'b1;
      end
      if (inst_ready) inst_hold <= rd_val;
      if (mem_ready && !we_q) mem_hold <= rd_val;
      if (to_fire) begin
        err <= 1'b1;
        if (!err) err_addr <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed per-feature tasks plus a ready-pulse scoreboard
// (bit DW of each expected entry selects the side: 0 = fetch, 1 = load/store).
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inst_ren = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic [DW-1:0] inst_data;
  logic          inst_ready;
  logic          mem_ren = 1'b0;
  logic          mem_wen = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_dout = '0;
  logic [DW-1:0] mem_din;
  logic          mem_ready;
  logic          port_req;
  logic          port_we;
  logic [AW-1:0] port_addr;
  logic [DW-1:0] port_wdata;
  logic          port_ack = 1'b0;
  logic [DW-1:0] port_rdata = '0;
  logic          if_stall;
  logic          mem_stall;
  logic          err;
  logic [AW-1:0] err_addr;
  logic [1:0]    dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [DW:0] exp_q[$];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_ready(inst_ready),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ready(mem_ready),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_ack(port_ack), .port_rdata(port_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall), .err(err), .err_addr(err_addr),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inst_ren = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    inst_addr = '0; mem_addr = '0; mem_dout = '0;
    port_ack = 1'b0; port_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    inst_ren = 1'b1; mem_ren = 1'b1; port_ack = 1'b1; port_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_vec++; if (port_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", port_req); end
    n_vec++; if ({inst_ready, mem_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready got=%b exp=00", {inst_ready, mem_ready}); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", err); end
    n_vec++; if (inst_data !== '0) begin n_err++; $display("FAIL rst_inst_data got=%h exp=0", inst_data); end
    n_vec++; if (mem_din !== '0) begin n_err++; $display("FAIL rst_mem_din got=%h exp=0", mem_din); end
    n_vec++; if (err_addr !== '0) begin n_err++; $display("FAIL rst_err_addr got=%h exp=0", err_addr); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    do_reset();
  endtask

  task automatic test_basic_fetch();
    do_reset();
    inst_ren = 1'b1; inst_addr = 32'h10;
    @(negedge clk);
    n_vec++; if (port_req !== 1'b0) begin n_err++; $display("FAIL basic_req_c0 got=%b exp=0", port_req); end
    n_vec++; if (if_stall !== 1'b1) begin n_err++; $display("FAIL basic_stall_c0 got=%b exp=1", if_stall); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (port_req !== 1'b1) begin n_err++; $display("FAIL basic_req_c1 got=%b exp=1", port_req); end
    n_vec++; if (port_addr !== 32'h10) begin n_err++; $display("FAIL basic_addr got=%h exp=10", port_addr); end
    n_vec++; if (port_we !== 1'b0) begin n_err++; $display("FAIL basic_we got=%b exp=0", port_we); end
    next_cycle();
    port_ack = 1'b1; port_rdata = 32'h2402_000A;
    exp_q.push_back({1'b0, 32'h2402_000A});
    @(negedge clk);
    n_vec++; if (if_stall !== 1'b0) begin n_err++; $display("FAIL basic_stall_ack got=%b exp=0", if_stall); end
    next_cycle();
    port_ack = 1'b0; inst_ren = 1'b0;
    @(negedge clk);
    n_vec++; if (inst_data !== 32'h2402_000A) begin n_err++; $display("FAIL basic_hold got=%h exp=2402000a", inst_data); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL basic_idle got=%0d exp=0", dbg_state); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL basic_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_alternation();
    logic [AW-1:0] ea;
    do_reset();
    inst_ren = 1'b1; inst_addr = 32'h20; mem_ren = 1'b1; mem_addr = 32'h80;
    for (int i = 0; i < 6; i++) begin
      port_ack = 1'b1;
      port_rdata = $urandom;
      if (i > 0) exp_q.push_back({(i % 2 == 1), port_rdata});
      @(negedge clk);
      if (i == 0) begin
        n_vec++; if (port_req !== 1'b0) begin n_err++; $display("FAIL alt_idle_req got=%b exp=0", port_req); end
      end else begin
        ea = (i % 2 == 1) ? 32'h80 : 32'h20;
        n_vec++; if (port_addr !== ea) begin n_err++; $display("FAIL alt_addr[%0d] got=%h exp=%h", i, port_addr, ea); end
      end
      next_cycle();
    end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL alt_sb_left got=%0d exp=0", exp_q.size()); end
    do_reset();
  endtask

  task automatic test_store();
    do_reset();
    mem_ren = 1'b1; mem_addr = 32'h44;
    next_cycle();
    port_ack = 1'b1; port_rdata = 32'h1122_3344;
    exp_q.push_back({1'b1, 32'h1122_3344});
    next_cycle();
    port_ack = 1'b0; port_rdata = 32'h0BAD_F00D;
    mem_wen = 1'b1; mem_addr = 32'h40; mem_dout = 32'hDEAD_BEEF;
    @(negedge clk);
    n_vec++; if (mem_din !== 32'h1122_3344) begin n_err++; $display("FAIL st_load_hold got=%h exp=11223344", mem_din); end
    for (int c = 3; c <= 6; c++) begin
      next_cycle();
      if (c == 4) mem_dout = '0;
      if (c == 6) begin port_ack = 1'b1; exp_q.push_back({1'b1, 32'h1122_3344}); end
      @(negedge clk);
      n_vec++; if (port_we !== 1'b1) begin n_err++; $display("FAIL st_we[%0d] got=%b exp=1", c, port_we); end
      n_vec++; if (port_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL st_wdata[%0d] got=%h exp=deadbeef", c, port_wdata); end
      n_vec++; if (port_addr !== 32'h40) begin n_err++; $display("FAIL st_addr[%0d] got=%h exp=40", c, port_addr); end
      n_vec++; if (mem_stall !== (c != 6)) begin n_err++; $display("FAIL st_stall[%0d] got=%b exp=%b", c, mem_stall, (c != 6)); end
    end
    next_cycle();
    port_ack = 1'b0; mem_wen = 1'b0; mem_ren = 1'b0;
    @(negedge clk);
    n_vec++; if (port_req !== 1'b0) begin n_err++; $display("FAIL st_req_end got=%b exp=0", port_req); end
    n_vec++; if (mem_din !== 32'h1122_3344) begin n_err++; $display("FAIL st_din_end got=%h exp=11223344", mem_din); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL st_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_withdraw();
    do_reset();
    inst_ren = 1'b1; inst_addr = 32'h30;
    next_cycle();
    port_ack = 1'b1; port_rdata = 32'hCAFE_0001;
    exp_q.push_back({1'b0, 32'hCAFE_0001});
    next_cycle();
    port_ack = 1'b0; inst_addr = 32'h34;
    next_cycle();
    @(negedge clk);
    n_vec++; if (port_addr !== 32'h34) begin n_err++; $display("FAIL wd_addr got=%h exp=34", port_addr); end
    for (int c = 4; c <= 6; c++) begin
      next_cycle();
      if (c == 4) inst_ren = 1'b0;
      if (c == 6) begin port_ack = 1'b1; port_rdata = 32'hBAD0_BAD0; end
      @(negedge clk);
      n_vec++; if (port_req !== 1'b1) begin n_err++; $display("FAIL wd_req[%0d] got=%b exp=1", c, port_req); end
      n_vec++; if (inst_data !== 32'hCAFE_0001) begin n_err++; $display("FAIL wd_data[%0d] got=%h exp=cafe0001", c, inst_data); end
    end
    next_cycle();
    port_ack = 1'b0;
    @(negedge clk);
    n_vec++; if (port_req !== 1'b0) begin n_err++; $display("FAIL wd_req_end got=%b exp=0", port_req); end
    n_vec++; if (inst_data !== 32'hCAFE_0001) begin n_err++; $display("FAIL wd_data_end got=%h exp=cafe0001", inst_data); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL wd_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_ren = 1'b1; mem_addr = 32'h100; port_rdata = 32'h5A5A_5A5A;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      if (c == 5) exp_q.push_back({1'b1, 32'h0});
      @(negedge clk);
      n_vec++; if (port_req !== (c != 5)) begin n_err++; $display("FAIL to_req[%0d] got=%b exp=%b", c, port_req, (c != 5)); end
    end
    next_cycle();
    mem_addr = 32'h200;
    @(negedge clk);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL to_err got=%b exp=1", err); end
    n_vec++; if (err_addr !== 32'h100) begin n_err++; $display("FAIL to_err_addr got=%h exp=100", err_addr); end
    for (int c = 7; c <= 11; c++) begin
      next_cycle();
      if (c == 11) exp_q.push_back({1'b1, 32'h0});
      @(negedge clk);
      n_vec++; if (port_req !== (c != 11)) begin n_err++; $display("FAIL to2_req[%0d] got=%b exp=%b", c, port_req, (c != 11)); end
    end
    next_cycle();
    mem_ren = 1'b0;
    @(negedge clk);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL to_err_sticky got=%b exp=1", err); end
    n_vec++; if (err_addr !== 32'h100) begin n_err++; $display("FAIL to_err_addr_first got=%h exp=100", err_addr); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL to_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_ren = 1'b1; mem_wen = 1'b1; mem_addr = 32'h300; mem_dout = 32'h77;
    inst_ren = 1'b1; inst_addr = 32'h50;
    next_cycle();
    @(negedge clk);
    n_vec++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL rm_data_first got=%0d exp=2", dbg_state); end
    n_vec++; if (port_we !== 1'b1) begin n_err++; $display("FAIL rm_we got=%b exp=1", port_we); end
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if ({port_req, port_we} !== 2'b00) begin n_err++; $display("FAIL rm_req_we got=%b exp=00", {port_req, port_we}); end
    n_vec++; if (port_addr !== '0) begin n_err++; $display("FAIL rm_addr got=%h exp=0", port_addr); end
    n_vec++; if (port_wdata !== '0) begin n_err++; $display("FAIL rm_wdata got=%h exp=0", port_wdata); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rm_state got=%0d exp=0", dbg_state); end
    mem_ren = 1'b0; mem_wen = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    n_vec++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL rm_inst_grant got=%0d exp=1", dbg_state); end
    n_vec++; if (port_addr !== 32'h50) begin n_err++; $display("FAIL rm_inst_addr got=%h exp=50", port_addr); end
    next_cycle();
    port_ack = 1'b1; port_rdata = 32'h1357_9BDF;
    exp_q.push_back({1'b0, 32'h1357_9BDF});
    next_cycle();
    port_ack = 1'b0; inst_ren = 1'b0;
    @(negedge clk);
    n_vec++; if (inst_data !== 32'h1357_9BDF) begin n_err++; $display("FAIL rm_inst_data got=%h exp=13579bdf", inst_data); end
    n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rm_sb_left got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    fork
      begin : sb_monitor
        logic [DW:0] e;
        forever begin
          @(negedge clk);
          if (rst_n && inst_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++; $display("FAIL sb_inst unexpected ready got=%h exp=none", inst_data);
            end else begin
              e = exp_q.pop_front();
              if ({1'b0, inst_data} !== e) begin n_err++; $display("FAIL sb_inst got=%h exp=%h", {1'b0, inst_data}, e); end
            end
          end
          if (rst_n && mem_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++; $display("FAIL sb_mem unexpected ready got=%h exp=none", mem_din);
            end else begin
              e = exp_q.pop_front();
              if ({1'b1, mem_din} !== e) begin n_err++; $display("FAIL sb_mem got=%h exp=%h", {1'b1, mem_din}, e); end
            end
          end
        end
      end
    join_none
    test_reset();
    test_basic_fetch();
    test_alternation();
    test_store();
    test_withdraw();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
